filter_sinc3_dec: RTL and testbench

Third-order sinc (CIC) decimator for a 1-bit sigma-delta modulator stream with run-time decimation rate and a single clock domain. Runs entirely on the modulator clock, generates its own decimation strobe instead of using a separate word clock, and emits a `WIDTH`-bit unsigned sample with a one-cycle `out_valid` pulse. Sits directly behind the modulator input pin and feeds the sample-processing logic.

---
 rtl/filter_sinc3_dec.sv | 164 ++++++++++++++++
 tb/tb_filter_sinc3_dec.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_sinc3_dec.sv
// -----------------------------------------------------------------------------
// filter_sinc3_dec
//
// Third-order sinc (CIC) decimator for a 1-bit sigma-delta bitstream. Runs on
// the modulator clock only and derives its own decimation strobe. Decimation
// rate is 2^L, with L taken from dec_log2 at each decimation boundary and
// clamped to [DEC_LOG2_MIN, DEC_LOG2_MAX].
//
// Build option:
//   FILTER_SINC3_SAT_EN  when defined, a full-scale sample (2^WIDTH) clamps to
//                        all ones and pulses ovf. When undefined, the sample
//                        wraps to 0 and ovf is constant 0.
//
// Ports:
//   mclkin     in   modulator clock (only clock)
//   rst_n      in   asynchronous active-low reset
//   mdata      in   modulator bitstream, sampled on rising mclkin
//   dec_log2   in   requested decimation exponent L (4 bits)
//   data       out  WIDTH-bit unsigned sample, held between updates
//   out_valid  out  one-cycle pulse when data updates with a settled sample
//   ovf        out  one-cycle pulse with out_valid when the sample was clamped
// -----------------------------------------------------------------------------
module filter_sinc3_dec #(
  parameter int WIDTH        = 16,
  parameter int DEC_LOG2_MAX = 8
) (
  input  logic             mclkin,
  input  logic             rst_n,
  input  logic             mdata,
  input  logic [3:0]       dec_log2,
  output logic [WIDTH-1:0] data,
  output logic             out_valid,
  output logic             ovf
);

  localparam int DEC_LOG2_MIN = (WIDTH + 2) / 3;
  localparam int ACC_W        = 3 * DEC_LOG2_MAX + 1;
  localparam int SH_W         = $clog2(ACC_W);
  localparam int CNT_W        = DEC_LOG2_MAX;

  localparam logic [3:0] L_MIN = 4'(DEC_LOG2_MIN);
  localparam logic [3:0] L_MAX = 4'(DEC_LOG2_MAX);

  typedef logic [ACC_W-1:0] acc_t;

  // State
  logic             d_in_q;
  acc_t             acc1_q, acc2_q, acc3_q;
  acc_t             acc3_dly_q, diff1_q, diff1_dly_q, diff2_q, diff2_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       l_q;
  logic             l_vld_q;   // l_q holds a loaded value (first cycle after reset uses the pin)
  logic [2:0]       settle_q;
  logic [WIDTH-1:0] data_q;
  logic             out_valid_q;
  logic             ovf_q;

  // Combinational
  logic [3:0]       l_req;
  logic [3:0]       l_cur;
  logic [CNT_W-1:0] cnt_last;
  logic             dec_stb;
  logic             l_change;
  logic             emit;
  acc_t             diff3_d;
  logic [SH_W-1:0]  sh_amt;
  logic [WIDTH-1:0] data_d;
  logic             sat;

  // NOTE: every variable written in an always_comb gets a default on entry,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    l_req = dec_log2;
    if (dec_log2 < L_MIN) begin
      l_req = L_MIN;
    end else if (dec_log2 > L_MAX) begin
      l_req = L_MAX;
    end
  end

  assign l_cur    = l_vld_q ? l_q : l_req;
  assign cnt_last = ~({CNT_W{1'b1}} << l_cur);
  assign dec_stb  = (cnt_q == cnt_last);

  // A boundary that changes L restarts settling and emits nothing: the comb
  // history belongs to the old window length and would be scaled wrongly.
  assign l_change = dec_stb && (l_req != l_cur);
  assign emit     = dec_stb && !l_change && (settle_q == 3'd4);

  // Third comb stage evaluated at the strobe so the scaled sample can be
  // registered straight into data, one cycle after the strobe.
  assign diff3_d = diff2_q - diff2_dly_q;
  assign sh_amt  = SH_W'(3 * int'(l_cur) - WIDTH);

`ifdef FILTER_SINC3_SAT_EN
  acc_t s_full;
  assign s_full = diff3_d >> sh_amt;
  assign sat    = |s_full[ACC_W-1:WIDTH];
  assign data_d = sat ? '1 : s_full[WIDTH-1:0];
`else
  assign sat    = 1'b0;
  assign data_d = WIDTH'(diff3_d >> sh_amt);
`endif

  always_ff @(posedge mclkin or negedge rst_n) begin
    if (!rst_n) begin
      d_in_q      <= 1'b0;
      acc1_q      <= '0;
      acc2_q      <= '0;
      acc3_q      <= '0;
      acc3_dly_q  <= '0;
      diff1_q     <= '0;
      diff1_dly_q <= '0;
      diff2_q     <= '0;
      diff2_dly_q <= '0;
      cnt_q       <= '0;
      l_q         <= '0;
      l_vld_q     <= 1'b0;
      settle_q    <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      d_in_q <= mdata;
      // NOTE: non-blocking assignments make each integrator add the previous
      // stage's value from before this edge, giving the pipelined cascade.
      acc1_q <= acc1_q + acc_t'(d_in_q);
      acc2_q <= acc2_q + acc1_q;
      acc3_q <= acc3_q + acc2_q;

      out_valid_q <= emit;
      ovf_q       <= emit & sat;

      if (!l_vld_q || dec_stb) begin
        l_q     <= l_req;
        l_vld_q <= 1'b1;
      end

      if (dec_stb) begin
        cnt_q       <= '0;
        acc3_dly_q  <= acc3_q;
        diff1_q     <= acc3_q - acc3_dly_q;
        diff1_dly_q <= diff1_q;
        diff2_q     <= diff1_q - diff1_dly_q;
        diff2_dly_q <= diff2_q;
        if (l_change) begin
          settle_q <= '0;
        end else if (settle_q != 3'd4) begin
          settle_q <= settle_q + 3'd1;
        end
        if (emit) begin
          data_q <= data_d;
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign data      = data_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_filter_sinc3_dec.sv
// -----------------------------------------------------------------------------
// tb_filter_sinc3_dec
//
// Scoreboard bench for filter_sinc3_dec. The stimulus process drives mdata and
// dec_log2 on falling edges and, at each decimation boundary, computes the
// expected sample from closed-form sums of the input history; a monitor pops
// and compares whenever out_valid is seen.
//
// Reference: mdata sampled at edge i contributes C(E-1-i, 2) to the third
// integrator after edge E. With A(k) that sum at the strobe ending window k,
// the sample emitted at boundary n is A(n-2) - 3A(n-3) + 3A(n-4) - A(n-5),
// shifted right by 3L - WIDTH.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_filter_sinc3_dec;

  localparam int WIDTH = 16;
  localparam int L_MIN = 6;
  localparam int L_MAX = 8;

  logic             mclkin   = 1'b0;
  logic             rst_n    = 1'b0;
  logic             mdata    = 1'b0;
  logic [3:0]       dec_log2 = 4'd8;
  logic [WIDTH-1:0] data;
  logic             out_valid;
  logic             ovf;

  filter_sinc3_dec #(.WIDTH(WIDTH), .DEC_LOG2_MAX(L_MAX)) dut (
    .mclkin    (mclkin),
    .rst_n     (rst_n),
    .mdata     (mdata),
    .dec_log2  (dec_log2),
    .data      (data),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  always #5 mclkin = ~mclkin;

  typedef struct {
    int               edge_no;
    logic [WIDTH-1:0] data;
    logic             ovf;
  } exp_t;

  exp_t   exp_q[$];
  int     checks   = 0;
  int     failures = 0;

  // Reference-model state
  bit     m_hist[$];   // m_hist[i] = mdata sampled at edge i after reset
  longint a_q[$];      // a_q[k] = third-integrator sum at the strobe ending window k
  int     e;           // number of the edge the current drive is for
  int     next_b;      // edge at which the next boundary takes effect
  int     cur_l;
  int     settle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_l(input int v);
    if (v < L_MIN) return L_MIN;
    if (v > L_MAX) return L_MAX;
    return v;
  endfunction

  function automatic longint get_a(input int k);
    if (k < 0) return 0;
    return a_q[k];
  endfunction

  task automatic model_reset();
    e = 0;
    m_hist.delete();
    m_hist.push_back(1'b0);
    a_q.delete();
    a_q.push_back(0);
    settle = 0;
    next_b = -1;
    cur_l  = L_MAX;
  endtask

  // Called while driving inputs for edge e == next_b.
  task automatic model_boundary(input int dl);
    longint a, n, d3, s;
    int     k, l_new;
    exp_t   x;
    a = 0;
    for (int i = 1; i <= e - 4; i++) begin
      if (m_hist[i]) begin
        n = longint'(e - 2 - i);
        a += n * (n - 1) / 2;
      end
    end
    a_q.push_back(a);
    k = a_q.size() - 1;
    l_new = clamp_l(dl);
    if (l_new != cur_l) begin
      settle = 0;
    end else if (settle == 4) begin
      d3 = get_a(k - 2) - 3 * get_a(k - 3) + 3 * get_a(k - 4) - get_a(k - 5);
      s  = d3 >> (3 * cur_l - WIDTH);
      x.edge_no = e;
`ifdef FILTER_SINC3_SAT_EN
      if (s >= (longint'(1) << WIDTH)) begin
        x.data = '1;
        x.ovf  = 1'b1;
      end else begin
        x.data = WIDTH'(s);
        x.ovf  = 1'b0;
      end
`else
      x.data = WIDTH'(s);
      x.ovf  = 1'b0;
`endif
      exp_q.push_back(x);
    end else begin
      settle++;
    end
    cur_l  = l_new;
    next_b = e + (1 << cur_l);
  endtask

  // Caller is at a falling edge: drive the inputs for the next rising edge,
  // update the model, then move on to the following falling edge.
  task automatic step(input bit m, input int dl);
    mdata    = m;
    dec_log2 = 4'(dl);
    e++;
    m_hist.push_back(m);
    if (e == 1) begin
      cur_l  = clamp_l(dl);
      next_b = 1 << cur_l;
    end else if (e == next_b) begin
      model_boundary(dl);
    end
    @(negedge mclkin);
  endtask

  // Monitor: compare every presented sample against the scoreboard.
  initial begin
    exp_t x;
    forever begin
      @(posedge mclkin);
      #1;
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got out_valid=1 data=0x%0h, expected no sample (edge %0d)", data, e);
        end else begin
          x = exp_q.pop_front();
          check("sample_edge", 32'(e), 32'(x.edge_no));
          check("data", 32'(data), 32'(x.data));
          check("ovf", 32'(ovf), 32'(x.ovf));
        end
      end else if (rst_n && ovf) begin
        check("ovf_without_valid", 32'(ovf), 32'd0);
      end
    end
  end

  initial begin
    int dl, p;
    bit alt;
    model_reset();
    repeat (3) @(negedge mclkin);
    check("reset_data", 32'(data), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    // All zeros, L=8
    repeat (7 * 256) step(1'b0, 8);
    // Step to all ones, L=8: ramp, then full scale
    repeat (10 * 256) step(1'b1, 8);
    // Alternating 1,0 at L=8
    alt = 1'b1;
    repeat (8 * 256) begin step(alt, 8); alt = ~alt; end
    // Switch to L=6 mid-stream
    repeat (10 * 64) begin step(alt, 6); alt = ~alt; end
    // Below-range request behaves as L=6 and does not restart settling
    repeat (7 * 64) begin step(alt, 3); alt = ~alt; end
    // Above-range request behaves as L=8
    repeat (7 * 256) begin step(alt, 15); alt = ~alt; end
    // Step 0 -> 1 at L=6
    repeat (8 * 64) step(1'b0, 6);
    repeat (8 * 64) step(1'b1, 6);

    // Random density and occasional random L requests
    dl = 6;
    for (int blk = 0; blk < 12; blk++) begin
      p = $urandom_range(0, 100);
      if (blk % 6 == 3) dl = $urandom_range(0, 15);
      for (int i = 0; i < 200; i++) step($urandom_range(0, 99) < p, dl);
    end

    // Reset in the middle of a window with a nonzero held sample
    dl = 6;
    repeat (8 * 64) begin step(alt, dl); alt = ~alt; end
    while ((next_b - e) < 20 || (next_b - e) > 40) begin step(alt, dl); alt = ~alt; end
    check("pre_reset_data", 32'(data), 32'h8000);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_data", 32'(data), 32'd0);
    check("async_reset_valid", 32'(out_valid), 32'd0);
    check("async_reset_ovf", 32'(ovf), 32'd0);
    repeat (3) @(negedge mclkin);
    check("held_reset_data", 32'(data), 32'd0);
    model_reset();
    rst_n = 1'b1;

    // Restart with random data at L=6, then random L
    p = $urandom_range(20, 80);
    repeat (10 * 64) step($urandom_range(0, 99) < p, 6);
    dl = $urandom_range(0, 15);
    repeat (1800) step($urandom_range(0, 99) < p, dl);

    check("pending_samples", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
